rayid_alloc_multi: RTL

- Parametrised rayID free-list allocator with an attached pixel-ID store. It generalises the shader's fixed 512-entry rayID FIFO, its self-initialisation and its pixstore.
- Hands out rayIDs to the primary-ray issue path and records the pixelID for each allocated ray.
- Accepts completed rayIDs from NUM_RET independent return channels (e.g. BM, miss path) under round-robin arbitration.
- Emits the (rayID, pixelID) pair downstream to colour conversion and recycles the ID.

---
 rtl/rayid_alloc_multi.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/rayid_alloc_multi.sv
// rayid_alloc_multi: rayID free-list allocator with an attached pixel-ID store.
// After reset the block fills its free FIFO with IDs 0..NUM_IDS-1, one per
// cycle. It then grants IDs to the primary-ray issue path and records the
// pixelID bound to each granted ray. It accepts finished rayIDs from NUM_RET
// return channels under round-robin arbitration and recycles each one. For
// every recycled ID it emits the (rayID, pixelID) pair downstream.
// Optional feature macro: RAYID_ALLOC_CHECK_EN (outstanding-ID bitmap with a
// sticky double-free flag). When the macro is undefined, err_dbl_free is 0.
module rayid_alloc_multi #(
  parameter int ID_W    = 9,
  parameter int NUM_IDS = 512,
  parameter int NUM_RET = 2,
  parameter int PIX_W   = 19
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    init_done,
  input  logic                    alloc_valid,
  input  logic [PIX_W-1:0]        alloc_pixelID,
  output logic                    alloc_stall,
  output logic [ID_W-1:0]         alloc_rayID,
  input  logic [NUM_RET-1:0]      ret_valid,
  input  logic [NUM_RET*ID_W-1:0] ret_rayID,
  output logic [NUM_RET-1:0]      ret_stall,
  output logic                    pix_valid,
  output logic [ID_W-1:0]         pix_rayID,
  output logic [PIX_W-1:0]        pix_pixelID,
  input  logic                    pix_stall,
  output logic [ID_W:0]           free_count,
  output logic                    err_dbl_free
);

  localparam int              RR_W     = (NUM_RET > 1) ? $clog2(NUM_RET) : 1;
  localparam logic [ID_W-1:0] LAST_ID  = ID_W'(NUM_IDS - 1);
  localparam logic [ID_W:0]   FULL_CNT = (ID_W+1)'(NUM_IDS);
  localparam logic [RR_W-1:0] RR_INIT  = RR_W'(NUM_RET - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e            state_q, state_d;
  logic              in_init, in_run;
  logic [ID_W-1:0]   init_cnt_q, init_cnt_d;
  logic [ID_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ID_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ID_W:0]     count_q, count_d;
  logic [RR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic              pix_valid_q, pix_valid_d;
  logic [ID_W-1:0]   pix_ray_q, pix_ray_d;
  logic [PIX_W-1:0]  pix_pix_q, pix_pix_d;

  logic [ID_W-1:0]   fifo_mem [NUM_IDS];
  logic [PIX_W-1:0]  pix_mem  [NUM_IDS];

  logic              win_found;
  logic [RR_W-1:0]   win_idx;
  logic              eligible;
  logic              accept;
  logic [ID_W-1:0]   acc_id;
  logic              dbl;
  logic              grant;
  logic              push;
  logic [ID_W-1:0]   push_id;
  logic              load;

  // Pointer increment that wraps at NUM_IDS, which need not be a power of two.
  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] p);
    return (p == LAST_ID) ? '0 : p + 1'b1;
  endfunction

  // Hold the FSM state. Reset always restarts self-initialisation.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_INIT;
    else     state_q <= state_d;
  end

  // Leave INIT once the final ID has been written into the free FIFO.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: if (init_cnt_q == LAST_ID) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  // Decode the state into the mode flags used by the datapath.
  always_comb begin
    in_init = (state_q == ST_INIT);
    in_run  = (state_q == ST_RUN);
  end

  assign init_done    = in_run;
  assign alloc_stall  = ~in_run | (count_q == '0);
  assign alloc_rayID  = fifo_mem[rd_ptr_q];
  assign grant        = alloc_valid & ~alloc_stall;
  assign free_count   = count_q;
  assign pix_valid    = pix_valid_q;
  assign pix_rayID    = pix_ray_q;
  assign pix_pixelID  = pix_pix_q;

  // Round-robin pick: the first valid channel at or after rr_ptr+1, with wrap-around.
  always_comb begin
    int cand;
    logic [RR_W-1:0] cand_idx;
    cand      = 0;
    cand_idx  = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM_RET; k++) begin
      cand = int'(rr_ptr_q) + 1 + k;
      if (cand >= NUM_RET) cand = cand - NUM_RET;
      cand_idx = RR_W'(cand);
      if (!win_found && ret_valid[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // Accept at most one return per cycle. A return is accepted only when the output slot can take a new pair and the free list still has room.
  always_comb begin
    eligible  = in_run & (~pix_valid_q | ~pix_stall) & (count_q < FULL_CNT);
    accept    = eligible & win_found;
    acc_id    = ret_rayID[int'(win_idx)*ID_W +: ID_W];
    ret_stall = '1;
    if (accept) ret_stall[win_idx] = 1'b0;
  end

`ifdef RAYID_ALLOC_CHECK_EN
  logic [NUM_IDS-1:0] outst_q, outst_d;
  logic               err_q, err_d;

  // Track outstanding IDs. A return whose ID is not outstanding is consumed and dropped, and it sets the sticky error flag.
  always_comb begin
    outst_d = outst_q;
    err_d   = err_q;
    dbl     = accept & ~outst_q[acc_id];
    if (grant)  outst_d[alloc_rayID] = 1'b1;
    if (accept) outst_d[acc_id]      = 1'b0;
    if (dbl)    err_d                = 1'b1;
  end

  // Bitmap and error-flag registers. Both are cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      outst_q <= '0;
      err_q   <= 1'b0;
    end else begin
      outst_q <= outst_d;
      err_q   <= err_d;
    end
  end

  assign err_dbl_free = err_q;
`else
  assign dbl          = 1'b0;
  assign err_dbl_free = 1'b0;
`endif

  // Next-state datapath: FIFO pointers, occupancy, arbiter pointer and output pair.
  always_comb begin
    push     = in_init | (accept & ~dbl);
    push_id  = in_init ? init_cnt_q : acc_id;
    load     = accept & ~dbl;

    init_cnt_d = in_init ? init_cnt_q + 1'b1 : init_cnt_q;
    rd_ptr_d   = grant ? next_ptr(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d   = push  ? next_ptr(wr_ptr_q) : wr_ptr_q;

    count_d = count_q;
    case ({push, grant})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    rr_ptr_d = accept ? win_idx : rr_ptr_q;

    pix_valid_d = pix_valid_q;
    pix_ray_d   = pix_ray_q;
    pix_pix_d   = pix_pix_q;
    if (load) begin
      pix_valid_d = 1'b1;
      pix_ray_d   = acc_id;
      pix_pix_d   = pix_mem[acc_id];
    end else if (pix_valid_q && !pix_stall) begin
      pix_valid_d = 1'b0;
    end
  end

  // Control registers. Reset drops every outstanding ray and empties the free list.
  always_ff @(posedge clk) begin
    if (rst) begin
      init_cnt_q  <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      rr_ptr_q    <= RR_INIT;
      pix_valid_q <= 1'b0;
      pix_ray_q   <= '0;
      pix_pix_q   <= '0;
    end else begin
      init_cnt_q  <= init_cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      rr_ptr_q    <= rr_ptr_d;
      pix_valid_q <= pix_valid_d;
      pix_ray_q   <= pix_ray_d;
      pix_pix_q   <= pix_pix_d;
    end
  end

  // Storage arrays: free-list slots and the pixelID bound to each granted ray.
  always_ff @(posedge clk) begin
    if (!rst && push)  fifo_mem[wr_ptr_q]  <= push_id;
    if (!rst && grant) pix_mem[alloc_rayID] <= alloc_pixelID;
  end

endmodule
